uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

- Shares the single UART transmitter among `NUM_REQ` byte sources using packet-locked round-robin arbitration.
- Each requester presents bytes with a valid/ack handshake and a `last` marker. The arbiter holds one requester's grant for a whole packet, drives `tx_start`/`tx_data` into the transmitter, and waits for `tx_done` between bytes.
- A watchdog flags a transmitter that never completes.
- The block sits between the command/status producers and the UART TX core, on the same clock as that core.

## Interface

Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_WIDTH`, 8: byte width.
- `MAX_BURST`, 16: maximum bytes per grant before forced release; 1..255.
- `TIMEOUT_CYCLES`, 1_000_000: `clk` cycles allowed from `tx_start` to `tx_done`.

Ports:
- `clk` in 1: single clock. All logic, including the `tx_done` input, is synchronous to it.
- `rst_n` in 1: synchronous, active-low reset.
- `req` in NUM_REQ: per-requester byte valid.
- `req_data` in NUM_REQ*DATA_WIDTH: requester i's byte at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_last` in NUM_REQ: the presented byte ends the packet.
- `ack` out NUM_REQ: one-cycle pulse; the requester's current byte was captured.
- `grant` out NUM_REQ: one-hot owner, held for the whole packet.
- `busy` out 1: the arbiter is not IDLE.
- `tx_start` out 1: one-cycle start pulse to the transmitter.
- `tx_data` out DATA_WIDTH: byte to the transmitter, stable from `tx_start` until `tx_done`.
- `tx_done` in 1: one-cycle completion pulse from the transmitter.
- `err` out 1: sticky timeout flag.
- `clr_err` in 1: clears `err`.

## Operation

States are IDLE, START and WAIT.

**IDLE**
- Active when `rst_n` is high and no packet is in flight.
- If any `req` is high, select the winner by round-robin, searching from `(ptr+1) mod NUM_REQ` upward with wrap.
- Capture the winner's `req_data` into `tx_data` and record `req_last`.
- Set `grant` to the winner, clear the burst count to 1, and go to START.

**START** (exactly one cycle)
- Assert `tx_start`, assert `ack[owner]`, load the watchdog counter, and go to WAIT.

**WAIT**
- `tx_done` is honored only here. A `tx_done` seen in START or IDLE is ignored.
- On `tx_done`, continue the packet when all of the following hold:
  - the recorded last flag is 0,
  - `req[owner]` is high,
  - burst count < `MAX_BURST`.
- To continue: capture the owner's `req_data`/`req_last`, increment the burst count, and go to START.
- Otherwise release: `ptr` ← owner, `grant` ← 0, go to IDLE.
- If the watchdog reaches `TIMEOUT_CYCLES` without `tx_done`: set `err`, release as above (`ptr` ← owner), and go to IDLE. No `ack` is given.

**Requester rules**
- Hold `req_data`/`req_last` stable while `req` is high and `ack` is low.
- Present the next byte no later than the cycle after `ack`.
- Dropping `req` mid-packet ends the packet at the next `tx_done`.

**`err`**
- Set by a timeout; cleared by `clr_err`.
- If a timeout and `clr_err` occur in the same cycle, set wins.

**Widths**
- The burst counter is 8 bits.
- The watchdog counter is `$clog2(TIMEOUT_CYCLES+1)` bits.
- `ptr` is `$clog2(NUM_REQ)` bits.

## Timing

**Reset** (`rst_n` low sampled at a `clk` edge):
- Next cycle: state IDLE, `ack`=0, `grant`=0, `busy`=0, `tx_start`=0, `tx_data`=0, `err`=0.
- `ptr` = NUM_REQ-1, so requester 0 has first priority.
- Reset mid-packet abandons the packet with no further `ack` or `tx_start`.

**Latency**
- `req` high sampled in IDLE at edge N: `tx_start`, `ack`, `grant` and `busy` are high in cycle N+1.
- `tx_done` sampled in WAIT at edge M with continuation: next `tx_start`/`ack` in cycle M+1.
- Release at edge M: IDLE in cycle M+1. A new arbitration is sampled at edge M+1, giving `tx_start` in cycle M+2. The minimum idle gap between packets is one cycle.

**Output behavior**
- `tx_start` and `ack` are never high for more than one consecutive cycle.
- `tx_start` and `ack[owner]` are always coincident.
- `busy` = (state != IDLE).
- `grant` changes only on the IDLE→START transition or on release.

## Test plan

1. **Reset state.** Hold `rst_n` low for 3 cycles with `req`=4'b1111 → all outputs 0 during reset. The first grant after release of reset goes to requester 0; `tx_start` occurs one cycle after the first sampled `req`.
2. **Packet lock.** Req0 sends 3 bytes 0xA1, 0xA2, 0xA3 (last on 0xA3) while req1 is also high → `tx_data` sequence is 0xA1, 0xA2, 0xA3, each started one cycle after the preceding `tx_done`. Then req1 is granted.
3. **Round-robin fairness.** All four requesters send 1-byte packets continuously → grant order 0, 1, 2, 3, 0, 1 with exactly one `ack` per packet.
4. **Burst cap.** With `MAX_BURST`=4, req2 streams 10 bytes with last=0 and req3 waiting → release after 4 bytes, req3 served next, req2 resumes afterwards.
5. **Watchdog timeout.** With `TIMEOUT_CYCLES`=50 and `tx_done` withheld → `err`=1 at cycle 50 after START, `grant`=0, next requester granted. Pulsing `clr_err` clears `err`.
6. **Edge cases.**
   - Spurious `tx_done` in IDLE or START → ignored.
   - Owner drops `req` mid-packet → release at the next `tx_done`.
   - Reset asserted in WAIT → IDLE with all outputs 0 the next cycle.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte sources with packet-locked round-robin
// arbitration, a per-grant burst cap and a per-byte completion watchdog.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int MAX_BURST      = 16,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            ack,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy,
    output logic                          tx_start,
    output logic [DATA_WIDTH-1:0]         tx_data,
    input  logic                          tx_done,
    output logic                          err,
    input  logic                          clr_err
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    // The watchdog holds 1 in the first WAIT cycle, so it expires TIMEOUT_CYCLES after tx_start.
    localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]      BURST_MAX = 8'(MAX_BURST);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                  state_r, state_s;
    logic [PTR_W-1:0]        ptr_r, ptr_s;
    logic [PTR_W-1:0]        owner_r, owner_s;
    logic [NUM_REQ-1:0]      grant_r, grant_s;
    logic [DATA_WIDTH-1:0]   tx_data_r, tx_data_s;
    logic                    last_r, last_s;
    logic [7:0]              burst_r, burst_s;
    logic [WD_W-1:0]         wd_r, wd_s;
    logic                    err_r, err_s;
    logic [NUM_REQ-1:0]      ack_r, ack_s;
    logic                    tx_start_r, tx_start_s;
    logic                    busy_r;
    logic                    timeout_s;
    logic                    cont_s;
    logic                    win_found_s;
    logic [PTR_W-1:0]        win_idx_s;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
        logic [NUM_REQ-1:0] vec;
        vec      = {NUM_REQ{1'b0}};
        vec[idx] = 1'b1;
        return vec;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] byte_of(input logic [NUM_REQ*DATA_WIDTH-1:0] bus,
                                                      input logic [PTR_W-1:0] idx);
        return bus[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
    endfunction

    // Round-robin winner: first active request at or after ptr+1, wrapping.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = ptr_r;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!win_found_s && req[(int'(ptr_r) + k) % NUM_REQ]) begin
                win_found_s = 1'b1;
                win_idx_s   = PTR_W'((int'(ptr_r) + k) % NUM_REQ);
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    assign cont_s = !last_r && req[owner_r] && (burst_r < BURST_MAX);

    // Next-state, capture, burst and watchdog logic.
    always_comb begin
        state_s   = state_r;
        ptr_s     = ptr_r;
        owner_s   = owner_r;
        grant_s   = grant_r;
        tx_data_s = tx_data_r;
        last_s    = last_r;
        burst_s   = burst_r;
        wd_s      = wd_r;
        timeout_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (win_found_s) begin
                    owner_s   = win_idx_s;
                    grant_s   = onehot(win_idx_s);
                    tx_data_s = byte_of(req_data, win_idx_s);
                    last_s    = req_last[win_idx_s];
                    burst_s   = 8'd1;
                    state_s   = ST_START;
                end else begin
                    grant_s = {NUM_REQ{1'b0}};
                end
            end
            ST_START: begin
                wd_s    = WD_W'(1);
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_done) begin
                    if (cont_s) begin
                        tx_data_s = byte_of(req_data, owner_r);
                        last_s    = req_last[owner_r];
                        burst_s   = burst_r + 8'd1;
                        state_s   = ST_START;
                    end else begin
                        ptr_s   = owner_r;
                        grant_s = {NUM_REQ{1'b0}};
                        state_s = ST_IDLE;
                    end
                end else if (wd_r >= WD_LAST) begin
                    timeout_s = 1'b1;
                    ptr_s     = owner_r;
                    grant_s   = {NUM_REQ{1'b0}};
                    state_s   = ST_IDLE;
                end else begin
                    wd_s = wd_r + WD_W'(1);
                end
            end
            default: begin
                grant_s = {NUM_REQ{1'b0}};
                state_s = ST_IDLE;
            end
        endcase
    end

    // Sticky error (a timeout beats a simultaneous clear) and registered strobes.
    always_comb begin
        if (timeout_s) begin
            err_s = 1'b1;
        end else if (clr_err) begin
            err_s = 1'b0;
        end else begin
            err_s = err_r;
        end
        if (state_s == ST_START) begin
            ack_s      = grant_s;
            tx_start_s = 1'b1;
        end else begin
            ack_s      = {NUM_REQ{1'b0}};
            tx_start_s = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            ptr_r      <= PTR_W'(NUM_REQ - 1);
            owner_r    <= {PTR_W{1'b0}};
            grant_r    <= {NUM_REQ{1'b0}};
            tx_data_r  <= {DATA_WIDTH{1'b0}};
            last_r     <= 1'b0;
            burst_r    <= 8'd0;
            wd_r       <= {WD_W{1'b0}};
            err_r      <= 1'b0;
            ack_r      <= {NUM_REQ{1'b0}};
            tx_start_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            ptr_r      <= ptr_s;
            owner_r    <= owner_s;
            grant_r    <= grant_s;
            tx_data_r  <= tx_data_s;
            last_r     <= last_s;
            burst_r    <= burst_s;
            wd_r       <= wd_s;
            err_r      <= err_s;
            ack_r      <= ack_s;
            tx_start_r <= tx_start_s;
            busy_r     <= (state_s != ST_IDLE);
        end
    end

    assign ack      = ack_r;
    assign grant    = grant_r;
    assign busy     = busy_r;
    assign tx_start = tx_start_r;
    assign tx_data  = tx_data_r;
    assign err      = err_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester queues and a transmitter model drive the DUT,
// a monitor logs every tx_start, and logs are compared with hand-written expected sequences.
module tb_uart_tx_arbiter;
    localparam int NR = 4;
    localparam int DW = 8;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic [NR-1:0]     req      = '0;
    logic [NR*DW-1:0]  req_data = '0;
    logic [NR-1:0]     req_last = '0;
    logic [NR-1:0]     ack;
    logic [NR-1:0]     grant;
    logic              busy;
    logic              tx_start;
    logic [DW-1:0]     tx_data;
    logic              tx_done;
    logic              err;
    logic              clr_err  = 1'b0;
    logic              model_done = 1'b0;
    logic              tx_force   = 1'b0;

    assign tx_done = model_done | tx_force;

    uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(4), .TIMEOUT_CYCLES(50)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_last(req_last),
        .ack(ack), .grant(grant), .busy(busy), .tx_start(tx_start), .tx_data(tx_data),
        .tx_done(tx_done), .err(err), .clr_err(clr_err)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         proto_err = 0;
    logic [8:0] rq [NR][$];
    int         log_data[$];
    int         log_grant[$];
    int         log_cyc[$];
    int         done_cyc[$];
    int         exp_d[$];
    int         exp_g[$];
    int         ack_cnt [NR];
    logic       tx_auto    = 1'b1;
    int         tx_delay   = 2;
    logic       tx_pending = 1'b0;
    int         tx_cnt     = 0;
    logic       prev_start = 1'b0;
    int         s_cyc      = 0;
    int         r_cyc      = 0;

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor, requester queues and transmitter model, all on the falling edge.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (tx_start) begin
                log_data.push_back(int'(tx_data));
                log_grant.push_back(int'(grant));
                log_cyc.push_back(cyc);
                if (ack !== grant || prev_start) proto_err++;
            end else if (ack !== '0) begin
                proto_err++;
            end
            for (int i = 0; i < NR; i++) begin
                if (ack[i]) begin
                    ack_cnt[i]++;
                    if (rq[i].size() > 0) void'(rq[i].pop_front());
                end
            end
        end
        prev_start = tx_start;
        model_done = 1'b0;
        if (tx_pending) begin
            if (tx_cnt == 0) begin
                model_done = 1'b1;
                done_cyc.push_back(cyc);
                tx_pending = 1'b0;
            end else begin
                tx_cnt--;
            end
        end
        if (rst_n && tx_start && tx_auto) begin
            tx_pending = 1'b1;
            tx_cnt     = tx_delay;
        end
        for (int i = 0; i < NR; i++) begin
            if (rq[i].size() > 0) begin
                req[i]             = 1'b1;
                req_data[i*DW +: DW] = rq[i][0][7:0];
                req_last[i]        = rq[i][0][8];
            end else begin
                req[i]             = 1'b0;
                req_data[i*DW +: DW] = '0;
                req_last[i]        = 1'b0;
            end
        end
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        rq[r].push_back({l, d});
    endtask

    task automatic clear_logs();
        log_data.delete();
        log_grant.delete();
        log_cyc.delete();
        done_cyc.delete();
        exp_d.delete();
        exp_g.delete();
        foreach (ack_cnt[i]) ack_cnt[i] = 0;
    endtask

    task automatic expect_pkt(input int d, input int g);
        exp_d.push_back(d);
        exp_g.push_back(g);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(rq[0].size() == 0 && rq[1].size() == 0 && rq[2].size() == 0 &&
                     rq[3].size() == 0 && !busy && !tx_start) && n < 400);
        check_eq({tag, "_drain_timeout"}, int'(n >= 400), 0);
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_start && n < 100);
        check_eq({tag, "_start_timeout"}, int'(n >= 100), 0);
    endtask

    task automatic check_log(input string tag);
        check_eq({tag, "_count"}, log_data.size(), exp_d.size());
        for (int k = 0; k < exp_d.size(); k++) begin
            if (k < log_data.size()) begin
                check_eq($sformatf("%s_data%0d", tag, k), log_data[k], exp_d[k]);
                check_eq($sformatf("%s_grant%0d", tag, k), log_grant[k], exp_g[k]);
            end
        end
    endtask

    initial begin
        // Reset state with every requester asking.
        clear_logs();
        for (int i = 0; i < NR; i++) push(i, 8'(8'h10 + i), 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq($sformatf("reset_outputs%0d", i),
                     int'({ack, grant, busy, tx_start, tx_data, err}), 0);
        end
        rst_n = 1'b1;
        r_cyc = cyc;
        for (int i = 0; i < NR; i++) expect_pkt(8'h10 + i, 1 << i);
        wait_drain("t1");
        check_log("t1_first_grants");
        if (log_cyc.size() > 0) check_eq("t1_first_start_cycle", log_cyc[0], r_cyc + 1);

        // Round-robin fairness: two 1-byte packets per requester.
        clear_logs();
        for (int i = 0; i < NR; i++) push(i, 8'(8'h20 + i), 1'b1);
        for (int i = 0; i < NR; i++) push(i, 8'(8'h30 + i), 1'b1);
        for (int i = 0; i < NR; i++) expect_pkt(8'h20 + i, 1 << i);
        for (int i = 0; i < NR; i++) expect_pkt(8'h30 + i, 1 << i);
        wait_drain("t3");
        check_log("t3_rr");
        for (int i = 0; i < NR; i++) check_eq($sformatf("t3_acks%0d", i), ack_cnt[i], 2);

        // Packet lock: req0 keeps the grant for 3 bytes while req1 waits.
        clear_logs();
        tx_delay = 3;
        push(0, 8'hA1, 1'b0); push(0, 8'hA2, 1'b0); push(0, 8'hA3, 1'b1);
        push(1, 8'hB1, 1'b1);
        expect_pkt(8'hA1, 1); expect_pkt(8'hA2, 1); expect_pkt(8'hA3, 1); expect_pkt(8'hB1, 2);
        wait_drain("t2");
        check_log("t2_lock");
        check_eq("t2_done_count", done_cyc.size(), 4);
        if (done_cyc.size() >= 2 && log_cyc.size() >= 3) begin
            check_eq("t2_restart1", log_cyc[1], done_cyc[0] + 1);
            check_eq("t2_restart2", log_cyc[2], done_cyc[1] + 1);
        end
        check_eq("t2_acks0", ack_cnt[0], 3);

        // Burst cap of 4: req2 streams 10 bytes, req3 gets in after the first 4.
        clear_logs();
        tx_delay = 1;
        for (int i = 0; i < 10; i++) push(2, 8'(8'hC0 + i), 1'(i == 9));
        push(3, 8'hD0, 1'b1);
        for (int i = 0; i < 4; i++) expect_pkt(8'hC0 + i, 4);
        expect_pkt(8'hD0, 8);
        for (int i = 4; i < 10; i++) expect_pkt(8'hC0 + i, 4);
        wait_drain("t4");
        check_log("t4_burst");

        // Watchdog: withhold tx_done for req0's byte; req1 follows the release.
        clear_logs();
        tx_auto = 1'b0;
        push(0, 8'hE0, 1'b1);
        push(1, 8'hE1, 1'b1);
        wait_start("t5");
        s_cyc = cyc;
        repeat (49) @(negedge clk);
        check_eq("t5_err_before", int'(err), 0);
        check_eq("t5_grant_before", int'(grant), 1);
        @(negedge clk);
        check_eq("t5_err_at_timeout", int'(err), 1);
        check_eq("t5_grant_released", int'(grant), 0);
        check_eq("t5_busy_released", int'(busy), 0);
        tx_auto = 1'b1;
        expect_pkt(8'hE0, 1); expect_pkt(8'hE1, 2);
        wait_drain("t5");
        check_log("t5_timeout");
        if (log_cyc.size() > 1) check_eq("t5_next_start_cycle", log_cyc[1], s_cyc + 51);
        check_eq("t5_acks0", ack_cnt[0], 1);
        check_eq("t5_err_sticky", int'(err), 1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check_eq("t5_err_cleared", int'(err), 0);

        // Spurious tx_done while idle, then during START of a two-byte packet from req1.
        clear_logs();
        tx_force = 1'b1;
        @(negedge clk);
        tx_force = 1'b0;
        @(negedge clk);
        check_eq("t6_idle_done_busy", int'({busy, tx_start}), 0);
        tx_auto = 1'b0;
        push(1, 8'hF0, 1'b0); push(1, 8'hF1, 1'b1);
        wait_start("t6a");
        tx_force = 1'b1;
        @(negedge clk);
        tx_force = 1'b0;
        check_eq("t6_start_done_busy", int'(busy), 1);
        check_eq("t6_start_done_grant", int'(grant), 2);
        @(negedge clk);
        check_eq("t6_start_done_hold", int'({busy, grant}), 5'h12);
        tx_auto = 1'b1;
        tx_force = 1'b1;
        @(negedge clk);
        tx_force = 1'b0;
        expect_pkt(8'hF0, 2); expect_pkt(8'hF1, 2);
        wait_drain("t6a");
        check_log("t6_spurious");

        // Owner drops req after two non-last bytes: release on the second tx_done.
        clear_logs();
        push(2, 8'h60, 1'b0); push(2, 8'h61, 1'b0);
        expect_pkt(8'h60, 4); expect_pkt(8'h61, 4);
        wait_drain("t6b");
        check_log("t6_drop");
        check_eq("t6_drop_done_count", done_cyc.size(), 2);
        check_eq("t6_drop_grant", int'(grant), 0);

        // Reset asserted while waiting for tx_done.
        clear_logs();
        tx_auto = 1'b0;
        push(3, 8'h70, 1'b0); push(3, 8'h71, 1'b1);
        wait_start("t6c");
        repeat (2) @(negedge clk);
        check_eq("t6_wait_busy", int'(busy), 1);
        rst_n   = 1'b0;
        tx_auto = 1'b1;
        @(negedge clk);
        check_eq("t6_reset_outputs", int'({ack, grant, busy, tx_start, tx_data, err}), 0);
        @(negedge clk);
        check_eq("t6_reset_hold", int'({ack, grant, busy, tx_start, tx_data, err}), 0);
        rst_n = 1'b1;
        expect_pkt(8'h70, 8); expect_pkt(8'h71, 8);
        wait_drain("t6c");
        check_log("t6_reset");
        check_eq("t6_reset_acks3", ack_cnt[3], 2);

        check_eq("protocol_errors", proto_err, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
